// File: rtl/div32_seq.sv
// div32_seq: iterative restoring divider for DIV/DIVU, one quotient bit per clock with sign fix-up.
// Optional macro DIV_EARLY_OUT_EN: when |A| < |B| the result is written without iterating.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sgn_q, sgn_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, mag_b_q, mag_b_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d, remd_q, remd_d;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   shift_s, trial_s;
  logic             early_s;

  assign mag_a_s = (Signed && A[WIDTH-1]) ? negate(A) : A;
  assign mag_b_s = (Signed && B[WIDTH-1]) ? negate(B) : B;
  // dvd_q doubles as the quotient shift register: its MSB feeds rem, quotient bits enter at the LSB
  assign shift_s = {rem_q, dvd_q[WIDTH-1]};
  assign trial_s = shift_s - {1'b0, mag_b_q};

`ifdef DIV_EARLY_OUT_EN
  assign early_s = (B != ZERO) && (mag_a_s < mag_b_s);
`else
  assign early_s = 1'b0;
`endif

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Quotient  = quot_q;
  assign Remainder = remd_q;
  assign DivByZero = dbz_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sgn_d   = sgn_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    zero_d  = zero_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    mag_b_d = mag_b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    remd_d  = remd_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          sgn_d   = Signed;
          neg_a_d = A[WIDTH-1];
          neg_b_d = B[WIDTH-1];
          mag_b_d = mag_b_s;
          zero_d  = (B == ZERO);
          rem_d   = ZERO;
          dvd_d   = mag_a_s;
          count_d = CW'(WIDTH);
          busy_d  = 1'b1;
          // divide-by-zero and early-out both report |A| as remainder; the FIX sign rule restores A
          if ((B == ZERO) || early_s) begin
            rem_d   = mag_a_s;
            dvd_d   = ZERO;
            state_d = S_FIX;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!trial_s[WIDTH]) begin
          rem_d = trial_s[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift_s[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        if (zero_q) begin
          quot_d = {WIDTH{1'b1}};
        end else if (sgn_q && (neg_a_q != neg_b_q)) begin
          quot_d = negate(dvd_q);
        end else begin
          quot_d = dvd_q;
        end
        remd_d  = (sgn_q && neg_a_q) ? negate(rem_q) : rem_q;
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= {CW{1'b0}};
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= ZERO;
      dvd_q   <= ZERO;
      mag_b_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= ZERO;
      remd_q  <= ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sgn_q   <= sgn_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      zero_q  <= zero_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      mag_b_q <= mag_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: expected results come from 64-bit integer division.
module tb_div32_seq;

  logic        Clk = 1'b0;
  logic        Reset, Start, Signed;
  logic [31:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [31:0] Quotient, Remainder;

  div32_seq #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 32'd1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int unsigned edge_n;
  } exp_t;

  exp_t scb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint to_int(input logic [31:0] v, input logic sgn);
    return sgn ? longint'($signed(v)) : longint'({32'd0, v});
  endfunction

  function automatic longint mag(input logic [31:0] v, input logic sgn);
    longint x;
    x = to_int(v, sgn);
    return (x < 0) ? -x : x;
  endfunction

  // Called at a negedge: drives the request, which is accepted on the next posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t   e;
    longint q, r;
    int     lat;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; lat = 1;
    end else begin
      q = to_int(a, sgn) / to_int(b, sgn);
      r = to_int(a, sgn) % to_int(b, sgn);
      e.q = q[31:0]; e.r = r[31:0]; e.dbz = 1'b0; lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (mag(a, sgn) < mag(b, sgn)) lat = 1;
`endif
    end
    e.edge_n = cyc + 32'd1 + 32'(lat);
    scb.push_back(e);
    Start = 1'b1; A = a; B = b; Signed = sgn;
    @(negedge Clk);
    Start = 1'b0; A = $urandom; B = $urandom; Signed = 1'($urandom_range(0, 1));
    check("busy_after_accept", 64'(Busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (scb.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("drain_timeout", 64'(scb.size()), 64'd0);
    scb.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("done_seen", 64'(Done), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_done"}, 64'(Done), 64'd0);
    check({tag, "_quot"}, 64'(Quotient), 64'd0);
    check({tag, "_rem"},  64'(Remainder), 64'd0);
    check({tag, "_dbz"},  64'(DivByZero), 64'd0);
  endtask

  // Monitor: every Done must match the oldest outstanding request, on its expected edge.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Done) begin
      if (scb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 with no request outstanding (edge %0d)", cyc);
      end else begin
        e = scb.pop_front();
        check("quotient",  64'(Quotient),  64'(e.q));
        check("remainder", 64'(Remainder), 64'(e.r));
        check("divbyzero", 64'(DivByZero), 64'(e.dbz));
        check("done_edge", 64'(cyc),       64'(e.edge_n));
        check("busy_at_done", 64'(Busy),   64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    Reset = 1'b1; Start = 1'b0; Signed = 1'b0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge Clk);
    check_zero_outputs("reset");
    Reset = 1'b0;
    @(negedge Clk);

    issue(32'd100, 32'd7, 1'b0);               wait_idle();
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);         wait_idle();
    issue(32'd100, 32'hFFFF_FFF9, 1'b1);       wait_idle();
    issue(32'd5, 32'd0, 1'b0);                 wait_idle();
    issue(32'd5, 32'd0, 1'b1);                 wait_idle();
    issue(32'd9, 32'd3, 1'b0);                 wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_idle();
    issue(32'd3, 32'd10, 1'b0);                wait_idle();

    // reset lands on edge k+10 of a running op; restart accepted on edge k+12
    issue(32'h1234_5678, 32'd13, 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    scb.delete();
    check_zero_outputs("midreset");
    @(negedge Clk);
    issue(32'd9, 32'd3, 1'b0);
    wait_idle();

    // Start while busy is dropped; Start during the Done cycle is accepted
    issue(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge Clk);
    Start = 1'b1; A = 32'd77; B = 32'd5; Signed = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    issue(32'd1, 32'd1, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: begin end
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0;
        3: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(51, 5000)); end
        4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
        5: begin a = 32'h8000_0000; if ($urandom_range(0, 1) == 0) b = 32'hFFFF_FFFF; end
        default: b = 32'd1;
      endcase
      issue(a, b, s);
      if (i % 3 == 0) wait_done();
      else wait_idle();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Multi-cycle iterative divider for the MIPS datapath: the inverse companion to the combinational ALU's MUL operation, executing DIV/DIVU.
- One quotient bit per clock, restoring algorithm on operand magnitudes, with sign fix-up.
- The control unit issues with Start and stalls on Busy; results go to the HI (Remainder) and LO (Quotient) registers on Done.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  issue request; sampled only in IDLE
- Signed  input  1  1 = DIV (two's complement), 0 = DIVU
- A  input  WIDTH  dividend
- B  input  WIDTH  divisor
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse: results valid
- Quotient  output  WIDTH  LO result
- Remainder  output  WIDTH  HI result
- DivByZero  output  1  B was zero for the last completed op

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset:
  - On any edge with Reset=1: state=IDLE; Busy, Done, DivByZero, Quotient and Remainder all 0; iteration counter 0.
  - Reset overrides Start and aborts any in-flight op with no Done.
- States:
  - IDLE -> RUN on Start=1 with B!=0.
  - IDLE -> FIX on Start=1 with B==0.
  - RUN -> RUN while count>1.
  - RUN -> FIX when count==1.
  - FIX -> IDLE always.
- Accept edge k (IDLE, Start=1):
  - Latch Signed and sign bits of A and B.
  - Latch |A| and |B|; magnitude is the operand itself when Signed=0.
  - Clear partial remainder; count=WIDTH; Busy<=1.
- RUN, edges k+1..k+WIDTH:
  - Shift {rem,dvd} left 1; trial = rem - |B| at WIDTH+1 bits.
  - If non-negative, rem=trial and shift in quotient bit 1; else keep rem and shift in 0.
  - count decrements each edge.
- FIX, edge k+WIDTH+1:
  - Quotient <= q, negated if Signed and sign(A)!=sign(B).
  - Remainder <= r, negated if Signed and sign(A)=1. The remainder takes the dividend's sign.
  - DivByZero<=0; Done<=1; Busy<=0.
- Latency:
  - Done high during the cycle after edge k+WIDTH+1 (33 edges for WIDTH=32).
  - Done clears on the next edge.
- Divide by zero (B==0 at accept):
  - FIX at edge k+1 writes Quotient=all ones, Remainder=A, DivByZero=1.
  - Done is high after edge k+1.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, Signed=1): Quotient=0x80000000, Remainder=0, with no special flag. This falls out of the magnitude path with WIDTH-bit wrap.
- Outputs hold:
  - Quotient, Remainder and DivByZero hold their values until the next FIX or Reset.
  - A, B and Signed may change after accept without affecting the result.
- Start handling:
  - Start while Busy=1 is ignored; it is not queued.
  - Start during the Done cycle (state IDLE) is accepted. Done still deasserts on that edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At accept, if B!=0 and |A|<|B| (magnitudes), go directly to FIX.
  - Quotient=0; Remainder=A unchanged, sign preserved; Done high after edge k+1.
- Undefined: such operands take the full WIDTH+1 edge path with identical results.

Test Plan:
- Unsigned, A=100, B=7, Signed=0, Start at edge k -> Done only during cycle after edge k+33, Quotient=14, Remainder=2, DivByZero=0, Busy high edges k..k+32.
- Signed, A=0xFFFFFF9C (-100), B=7, Signed=1 -> Quotient=0xFFFFFFF2 (-14), Remainder=0xFFFFFFFE (-2). Repeat A=100, B=0xFFFFFFF9 -> Quotient=0xFFFFFFF2, Remainder=2.
- Divide by zero, A=5, B=0 (either Signed) -> Done after edge k+1, Quotient=0xFFFFFFFF, Remainder=5, DivByZero=1. The next valid op clears DivByZero.
- Overflow, A=0x80000000, B=0xFFFFFFFF, Signed=1 -> Quotient=0x80000000, Remainder=0.
- Reset at edge k+10 of a running op -> Busy=0, Done never pulses, all outputs 0. A Start at edge k+12 with A=9, B=3 -> Quotient=3, Remainder=0, Done after edge k+45.
- Start pulsed at k+5 (ignored, result unchanged), then Start re-asserted during the Done cycle with A=1, B=1 -> accepted, second Done after 33 more edges. With DIV_EARLY_OUT_EN, A=3, B=10 -> Done after edge k+1, Quotient=0, Remainder=3.
